// File: rtl/memoria_arbitro.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// After reset it clears every memory word, then grants one request per cycle.
module memoria_arbitro #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  init_done,
  output logic                  state_dbg
);

  // Handshake: req_x stays high until gnt_x; an access is accepted in exactly
  // the cycle where req_x && gnt_x, and gnt_x is decided combinationally that cycle.
  typedef enum logic {S_INIT = 1'b0, S_ARB = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    last_b_q, last_b_d;
  logic                    rvalid_a_q, rvalid_a_d;
  logic                    rvalid_b_q, rvalid_b_d;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      last_b_q   <= 1'b1;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_b_q   <= last_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_b_d   = last_b_q;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    case (state_q)
      S_INIT: begin
        // Counter wraps to zero on the last clear write.
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = S_ARB;
      end
      S_ARB: begin
        if (gnt_a) begin
          last_b_d   = 1'b0;
          rvalid_a_d = ~we_a;
        end else if (gnt_b) begin
          last_b_d   = 1'b1;
          rvalid_b_d = ~we_b;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (state_q == S_ARB) begin
      // On contention the port that was not granted last wins.
      gnt_a = req_a & (~req_b | last_b_q);
      gnt_b = req_b & (~req_a | ~last_b_q);
    end
    if (state_q == S_INIT && reset_L) begin
      mem_we   = 1'b1;
      mem_addr = cnt_q;
    end else if (gnt_a) begin
      mem_we   = we_a;
      mem_addr = addr_a;
      mem_data = data_a;
    end else if (gnt_b) begin
      mem_we   = we_b;
      mem_addr = addr_b;
      mem_data = data_b;
    end
  end

  assign rvalid_a  = rvalid_a_q;
  assign rvalid_b  = rvalid_b_q;
  assign rdata_a   = rvalid_a_q ? mem_q : '0;
  assign rdata_b   = rvalid_b_q ? mem_q : '0;
  assign init_done = (state_q == S_ARB);
  assign state_dbg = (state_q == S_ARB);

endmodule

// File: doc/memoria_arbitro.md
MEMORIA_ARBITRO -- requirements
Module: memoria_arbitro

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data width of both request ports and the memory data bus.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the address width; the memory depth SHALL be 2**ADDR_WIDTH words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_L  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_x (x=a,b)  input  1  SHALL request one memory access; held high until gnt_x.
REQ-006 we_x  input  1  SHALL select the access type: 1 = write, 0 = read; valid while req_x=1.
REQ-007 addr_x  input  ADDR_WIDTH  SHALL carry the access address.
REQ-008 data_x  input  DATA_WIDTH  SHALL carry the write data.
REQ-009 gnt_x  output  1  SHALL accept the request of port x in the current cycle.
REQ-010 rvalid_x  output  1  SHALL mark rdata_x valid for a granted read.
REQ-011 rdata_x  output  DATA_WIDTH  SHALL carry the read data.
REQ-012 mem_addr  output  ADDR_WIDTH  SHALL drive the memory address.
REQ-013 mem_data  output  DATA_WIDTH  SHALL drive the memory write data.
REQ-014 mem_we  output  1  SHALL drive the memory write enable.
REQ-015 mem_q  input  DATA_WIDTH  SHALL receive memory read data: word at the address registered on the previous edge.
REQ-016 init_done  output  1  SHALL indicate that memory clear has completed and arbitration is active.

Function
REQ-017 FSM SHALL have two states: INIT (memory clear) and ARB (arbitration); reset entry state SHALL be INIT.
REQ-018 INIT: one write per cycle, mem_we=1, mem_data=0, mem_addr = clear counter, starting at 0 and incrementing by 1.
REQ-019 INIT: when the clear counter equals 2**ADDR_WIDTH-1, that write completes; counter wraps to 0; FSM enters ARB; init_done=1 from the next cycle; INIT lasts exactly 2**ADDR_WIDTH cycles.
REQ-020 INIT: gnt_a=gnt_b=0 regardless of requests.
REQ-021 ARB: at most one of gnt_a/gnt_b SHALL be 1 per cycle; gnt_x is combinational from req_x and the priority pointer (same-cycle grant).
REQ-022 ARB: single requester -> that requester is granted.
REQ-023 ARB: both requesting -> grant the port not granted most recently (round-robin pointer); pointer reset value = "B last", so A wins the first contest.
REQ-024 The pointer SHALL update only on a grant.
REQ-025 Granted port SHALL drive mem_addr=addr_x, mem_data=data_x, mem_we=we_x in the grant cycle.
REQ-026 No grant in ARB: mem_we=0, mem_addr=0, mem_data=0.
REQ-027 Granted read (we_x=0) in cycle N: rvalid_x=1 in cycle N+1 only; rdata_x=mem_q in N+1.
REQ-028 rdata_x SHALL be 0 whenever rvalid_x=0.
REQ-029 Granted write: no rvalid pulse.
REQ-030 Write to address K in cycle N, read of K granted in N+1: read returns the newly written data.
REQ-031 Back-to-back grants (one per cycle, either port) SHALL be sustained with no bubble; rvalid_a and rvalid_b are never high together.

Reset
REQ-032 reset_L=0 SHALL immediately force: gnt_a=gnt_b=0, rvalid_a=rvalid_b=0, rdata_a=rdata_b=0, mem_we=0, mem_addr=0, mem_data=0, init_done=0, clear counter=0, pointer="B last", state INIT.
REQ-033 Reset asserted mid-INIT or mid-ARB SHALL drop any pending rvalid; on release, INIT restarts at address 0.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8)
REQ-034 Release reset -> mem_we=1, mem_addr 0..15 over 16 consecutive cycles, mem_data=0; init_done=1 on cycle 17; no gnt during INIT even with req_a=1.
REQ-035 ARB, req_a write addr 3 data 0xA5; next cycle req_a read addr 3 -> gnt_a both cycles; rvalid_a=1, rdata_a=0xA5 one cycle after the read grant.
REQ-036 req_a=req_b=1 held for 4 cycles -> gnts alternate A,B,A,B; never both high.
REQ-037 Read of an unwritten address 9 after INIT -> rdata_b=0x00 with rvalid_b=1 one cycle later.
REQ-038 Read granted, reset_L pulsed low before the next edge -> rvalid stays 0; INIT restarts at mem_addr=0.
REQ-039 No requests in ARB -> mem_we=0, mem_addr=0, mem_data=0, rvalid_a=rvalid_b=0 every cycle.
